// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch traceback walker: move codes,
// the gap symbol and the walker state encoding.
package nw_pkg;

    localparam logic [2:0] DIR_DIAG = 3'b001;
    localparam logic [2:0] DIR_LEFT = 3'b100;
    localparam logic [2:0] DIR_UP   = 3'b010;
    localparam logic [2:0] DIR_NONE = 3'b000;

    // Gap symbol used by the processing stage when building aligned strings.
    localparam logic [2:0] DASH = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/nw_traceback_walker_if.sv
// Bundle of control, memory-read and processing-stage signals of the
// traceback walker. The slave modport is the walker, the master modport is
// the environment (controller, memories and processing stage).
interface nw_traceback_walker_if #(
    parameter int N      = 128,
    parameter int IDX_W  = $clog2(N + 1),
    parameter int ADDR_W = $clog2(N)
) ();

    logic              start;
    logic [IDX_W-1:0]  lenA;
    logic [IDX_W-1:0]  lenB;
    logic [IDX_W-1:0]  dir_i;
    logic [IDX_W-1:0]  dir_j;
    logic [2:0]        dir_data;
    logic [ADDR_W-1:0] seqA_addr;
    logic [ADDR_W-1:0] seqB_addr;
    logic [2:0]        seqA_data;
    logic [2:0]        seqB_data;
    logic [2:0]        SeqA_i_t;
    logic [2:0]        SeqB_j_t;
    logic [2:0]        symbol_out;
    logic              busy;
    logic              done;
    logic              err;
    logic [IDX_W:0]    steps;

    modport slave (
        input  start, lenA, lenB, dir_data, seqA_data, seqB_data,
        output dir_i, dir_j, seqA_addr, seqB_addr, SeqA_i_t, SeqB_j_t,
               symbol_out, busy, done, err, steps
    );

    modport master (
        output start, lenA, lenB, dir_data, seqA_data, seqB_data,
        input  dir_i, dir_j, seqA_addr, seqB_addr, SeqA_i_t, SeqB_j_t,
               symbol_out, busy, done, err, steps
    );

endinterface

// File: rtl/nw_tb_move_decode.sv
// Move decoder for one traceback step: turns the boundary flags and the
// direction code into a move code, row/column decrements and an illegal flag.
module nw_tb_move_decode
    import nw_pkg::*;
(
    input  logic       i_i_zero,
    input  logic       i_j_zero,
    input  logic [2:0] i_dir,
    output logic [2:0] o_move,
    output logic       o_di,
    output logic       o_dj,
    output logic       o_illegal
);

    // On row 0 or column 0 only one move is possible, so the matrix is ignored.
    always_comb begin
        o_move    = DIR_NONE;
        o_di      = 1'b0;
        o_dj      = 1'b0;
        o_illegal = 1'b0;
        if (i_i_zero && !i_j_zero) begin
            o_move = DIR_LEFT;
            o_dj   = 1'b1;
        end else if (i_j_zero && !i_i_zero) begin
            o_move = DIR_UP;
            o_di   = 1'b1;
        end else if (!i_i_zero && !i_j_zero) begin
            case (i_dir)
                DIR_DIAG: begin
                    o_move = DIR_DIAG;
                    o_di   = 1'b1;
                    o_dj   = 1'b1;
                end
                DIR_LEFT: begin
                    o_move = DIR_LEFT;
                    o_dj   = 1'b1;
                end
                DIR_UP: begin
                    o_move = DIR_UP;
                    o_di   = 1'b1;
                end
                default: o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/nw_traceback_walker.sv
// Traceback walker: steps from (lenA, lenB) back to (0,0) through the
// direction matrix, one READ/EMIT pair per move, and hands each move code and
// its two sequence symbols to the processing stage.
module nw_traceback_walker
    import nw_pkg::*;
#(
    parameter int N = 128
) (
    input  logic clk,
    input  logic rst,
    nw_traceback_walker_if.slave bus
);

    localparam int IDX_W  = $clog2(N + 1);
    localparam int ADDR_W = $clog2(N);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W:0]   ONE_STEP = (IDX_W + 1)'(1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_i;
    logic [IDX_W-1:0]   r_j;
    logic [IDX_W:0]     r_steps;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [2:0]         r_sym;
    logic [2:0]         r_sym_a;
    logic [2:0]         r_sym_b;

    logic               w_i_zero;
    logic               w_j_zero;
    logic [2:0]         w_move;
    logic               w_di;
    logic               w_dj;
    logic               w_illegal;
    logic [IDX_W-1:0]   w_i_next;
    logic [IDX_W-1:0]   w_j_next;

    assign w_i_zero = (r_i == '0);
    assign w_j_zero = (r_j == '0);

    nw_tb_move_decode u_decode (
        .i_i_zero  (w_i_zero),
        .i_j_zero  (w_j_zero),
        .i_dir     (bus.dir_data),
        .o_move    (w_move),
        .o_di      (w_di),
        .o_dj      (w_dj),
        .o_illegal (w_illegal)
    );

    assign w_i_next = r_i - {{(IDX_W - 1){1'b0}}, w_di};
    assign w_j_next = r_j - {{(IDX_W - 1){1'b0}}, w_dj};

    // Addresses follow the current cell; index 0 reads address 0 and the
    // returned symbol is simply not meaningful for that move.
    assign bus.dir_i     = r_i;
    assign bus.dir_j     = r_j;
    assign bus.seqA_addr = w_i_zero ? '0 : ADDR_W'(r_i - ONE_IDX);
    assign bus.seqB_addr = w_j_zero ? '0 : ADDR_W'(r_j - ONE_IDX);

    assign bus.symbol_out = r_sym;
    assign bus.SeqA_i_t   = r_sym_a;
    assign bus.SeqB_j_t   = r_sym_b;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.steps      = r_steps;

    // Walker FSM with registered outputs; symbol and done default to idle values each cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_steps <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_sym   <= DIR_NONE;
            r_sym_a <= '0;
            r_sym_b <= '0;
        end else begin
            r_done <= 1'b0;
            r_sym  <= DIR_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_i     <= bus.lenA;
                        r_j     <= bus.lenB;
                        r_steps <= '0;
                        r_err   <= 1'b0;
                        if (bus.lenA == '0 && bus.lenB == '0) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (w_illegal) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_sym   <= w_move;
                        r_sym_a <= bus.seqA_data;
                        r_sym_b <= bus.seqB_data;
                        r_steps <= r_steps + ONE_STEP;
                        r_i     <= w_i_next;
                        r_j     <= w_j_next;
                        if (w_i_next == '0 && w_j_next == '0) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nw_traceback_walker.sv
// Bench for the traceback walker. Each walk is planned as a path from
// (lenA, lenB) to (0,0); the direction matrix is filled with random codes and
// the planned path is written over it, so the expected move list, timing and
// final status come straight from the plan.
module tb_nw_traceback_walker;

    localparam int N      = 16;
    localparam int IDX_W  = $clog2(N + 1);
    localparam int ADDR_W = $clog2(N);

    localparam logic [2:0] C_DIAG = 3'b001;
    localparam logic [2:0] C_LEFT = 3'b100;
    localparam logic [2:0] C_UP   = 3'b010;
    localparam logic [2:0] C_NONE = 3'b000;

    typedef struct {
        logic [2:0] code;
        logic [2:0] a;
        logic [2:0] b;
        int         pi;
        int         pj;
    } mv_t;

    logic clk;
    logic rst;

    nw_traceback_walker_if #(.N(N)) bus ();

    nw_traceback_walker #(.N(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [2:0] dir_mat  [0:N][0:N];
    logic [2:0] seqA_mem [0:N-1];
    logic [2:0] seqB_mem [0:N-1];

    mv_t        exp_q[$];
    logic [2:0] plan_q[$];
    int         la_g, lb_g, fin_i, fin_j;
    bit         exp_err;
    logic [2:0] hold_a, hold_b;
    int         total = 0;
    int         bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Direction and sequence memories, one cycle read latency.
    always @(posedge clk) begin
        bus.dir_data  <= dir_mat[bus.dir_i][bus.dir_j];
        bus.seqA_data <= seqA_mem[bus.seqA_addr];
        bus.seqB_data <= seqB_mem[bus.seqB_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " symbol"}, 32'(bus.symbol_out), 0);
        chk({tag, " SeqA"},   32'(bus.SeqA_i_t), 0);
        chk({tag, " SeqB"},   32'(bus.SeqB_j_t), 0);
        chk({tag, " dir_i"},  32'(bus.dir_i), 0);
        chk({tag, " dir_j"},  32'(bus.dir_j), 0);
        chk({tag, " addrA"},  32'(bus.seqA_addr), 0);
        chk({tag, " addrB"},  32'(bus.seqB_addr), 0);
        chk({tag, " busy"},   32'(bus.busy), 0);
        chk({tag, " done"},   32'(bus.done), 0);
        chk({tag, " err"},    32'(bus.err), 0);
        chk({tag, " steps"},  32'(bus.steps), 0);
    endtask

    // Fill memories, then write the planned path into the matrix and record it.
    task automatic build_walk(input int la, input int lb, input int err_at, input logic [2:0] err_code);
        int i, j, q, r;
        logic [2:0] code;
        mv_t m;
        for (int ii = 0; ii <= N; ii++)
            for (int jj = 0; jj <= N; jj++)
                dir_mat[ii][jj] = 3'($urandom_range(0, 7));
        for (int k = 0; k < N; k++) begin
            seqA_mem[k] = 3'($urandom_range(0, 7));
            seqB_mem[k] = 3'($urandom_range(0, 7));
        end
        exp_q.delete();
        exp_err = 1'b0;
        i = la;
        j = lb;
        q = 0;
        while (i > 0 || j > 0) begin
            if (i > 0 && j > 0) begin
                if (q == err_at) begin
                    dir_mat[i][j] = err_code;
                    exp_err = 1'b1;
                    break;
                end
                if (plan_q.size() > 0) begin
                    code = plan_q.pop_front();
                end else begin
                    r = int'($urandom_range(0, 2));
                    code = (r == 0) ? C_DIAG : ((r == 1) ? C_LEFT : C_UP);
                end
                dir_mat[i][j] = code;
            end else if (i == 0) begin
                code = C_LEFT;
            end else begin
                code = C_UP;
            end
            m.code = code;
            m.pi   = i;
            m.pj   = j;
            m.a    = seqA_mem[(i > 0) ? i - 1 : 0];
            m.b    = seqB_mem[(j > 0) ? j - 1 : 0];
            exp_q.push_back(m);
            if (code == C_DIAG) begin
                i--;
                j--;
            end else if (code == C_LEFT) begin
                j--;
            end else begin
                i--;
            end
            q++;
        end
        fin_i = i;
        fin_j = j;
        la_g  = la;
        lb_g  = lb;
    endtask

    // Start the planned walk and check every output on every cycle until it settles.
    task automatic run_walk(input bit poke);
        int nl, kk, mi, pi, pj, es_steps;
        logic [2:0] es;
        nl = exp_q.size();
        kk = exp_err ? nl + 1 : nl;
        @(negedge clk);
        bus.start = 1'b1;
        bus.lenA  = IDX_W'(la_g);
        bus.lenB  = IDX_W'(lb_g);
        @(posedge clk);
        for (int c = 1; c <= 2 * kk + 3; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            es = C_NONE;
            if (c >= 3 && (c % 2) == 1 && (c - 3) / 2 < nl) begin
                es     = exp_q[(c - 3) / 2].code;
                hold_a = exp_q[(c - 3) / 2].a;
                hold_b = exp_q[(c - 3) / 2].b;
            end
            es_steps = ((c - 1) / 2 < nl) ? (c - 1) / 2 : nl;
            chk("symbol", 32'(bus.symbol_out), 32'(es));
            chk("SeqA_i_t", 32'(bus.SeqA_i_t), 32'(hold_a));
            chk("SeqB_j_t", 32'(bus.SeqB_j_t), 32'(hold_b));
            chk("done", 32'(bus.done), 32'(c == 2 * kk + 1));
            chk("busy", 32'(bus.busy), 32'(c >= 1 && c <= 2 * kk));
            chk("err", 32'(bus.err), 32'(exp_err && c >= 2 * kk + 1));
            chk("steps", 32'(bus.steps), 32'(es_steps));
            if ((c % 2) == 1 && c <= 2 * kk - 1) begin
                mi = (c - 1) / 2;
                pi = (mi < nl) ? exp_q[mi].pi : fin_i;
                pj = (mi < nl) ? exp_q[mi].pj : fin_j;
                chk("dir_i", 32'(bus.dir_i), 32'(pi));
                chk("dir_j", 32'(bus.dir_j), 32'(pj));
                chk("seqA_addr", 32'(bus.seqA_addr), 32'((pi > 0) ? pi - 1 : 0));
                chk("seqB_addr", 32'(bus.seqB_addr), 32'((pj > 0) ? pj - 1 : 0));
            end
            if (c == 2 * kk + 1) begin
                chk("final_i", 32'(bus.dir_i), 32'(fin_i));
                chk("final_j", 32'(bus.dir_j), 32'(fin_j));
            end
            if (poke && kk >= 2 && c == 2) begin
                bus.start = 1'b1;
                bus.lenA  = '0;
                bus.lenB  = '0;
            end
            if (c == 3) bus.start = 1'b0;
        end
        $display("walk lenA=%0d lenB=%0d moves=%0d err=%0d poke=%0d checks=%0d bad=%0d",
                 la_g, lb_g, nl, exp_err, poke, total, bad);
    endtask

    initial begin
        int la, lb, ea, ci;
        logic [2:0] ecode;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.lenA  = '0;
        bus.lenB  = '0;
        hold_a = '0;
        hold_b = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 3x3 all-diagonal walk
        plan_q = '{C_DIAG, C_DIAG, C_DIAG};
        build_walk(3, 3, -1, C_NONE);
        run_walk(1'b0);

        // column 0: moves are forced up whatever the matrix holds
        build_walk(2, 0, -1, C_NONE);
        dir_mat[2][0] = C_DIAG;
        dir_mat[1][0] = 3'b011;
        run_walk(1'b0);

        // left, left, diagonal
        plan_q = '{C_LEFT, C_LEFT, C_DIAG};
        build_walk(1, 3, -1, C_NONE);
        run_walk(1'b0);

        // illegal code at (2,2), then a clean walk clears err
        build_walk(2, 2, 0, 3'b011);
        run_walk(1'b0);
        build_walk(0, 4, -1, C_NONE);
        run_walk(1'b0);

        // empty alignment
        build_walk(0, 0, -1, C_NONE);
        run_walk(1'b0);

        // reset during the second move abandons the walk
        plan_q = '{C_DIAG, C_DIAG, C_DIAG};
        build_walk(3, 3, -1, C_NONE);
        @(negedge clk);
        bus.start = 1'b1;
        bus.lenA  = IDX_W'(3);
        bus.lenB  = IDX_W'(3);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset symbol", 32'(bus.symbol_out), 32'(C_DIAG));
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midwalk reset");
        rst = 1'b1;
        hold_a = '0;
        hold_b = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post-reset done", 32'(bus.done), 0);
            chk("post-reset busy", 32'(bus.busy), 0);
        end
        $display("walk lenA=3 lenB=3 aborted by reset checks=%0d bad=%0d", total, bad);
        run_walk(1'b0);

        // random legal walks, some with a start pulse while busy
        for (int t = 0; t < 12; t++) begin
            la = int'($urandom_range(0, N));
            lb = int'($urandom_range(0, N));
            if (t == 0) la = N;
            if (t == 1) begin
                la = N;
                lb = N;
            end
            build_walk(la, lb, -1, C_NONE);
            run_walk(t % 3 == 0);
        end

        // random walks that hit an illegal code
        for (int t = 0; t < 4; t++) begin
            la = int'($urandom_range(1, N));
            lb = int'($urandom_range(1, N));
            ea = int'($urandom_range(0, 2));
            ci = int'($urandom_range(0, 4));
            case (ci)
                0:       ecode = 3'b000;
                1:       ecode = 3'b011;
                2:       ecode = 3'b101;
                3:       ecode = 3'b110;
                default: ecode = 3'b111;
            endcase
            build_walk(la, lb, ea, ecode);
            run_walk(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
